// File: rtl/pipe_pkg.sv
// Shared types for pipeline stage buffers.
// ID/EX bundle layouts, widths and the buffer state encoding.
package pipe_pkg;

  localparam int IDEX_CTRL_W = 15;
  localparam int IDEX_DATA_W = 175;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic       jump;
    logic       alu_src;
    logic       lui;
    logic       auipc;
    logic [3:0] alu_op;
    logic [1:0] wb_sel;
  } idex_ctrl_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } idex_data_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stage_state_e;

  function automatic logic [1:0] occ_of(stage_state_e s);
    unique case (s)
      ONE:     return 2'd1;
      FULL:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One ctrl+data payload register of a stage buffer.
// Clears take priority over load so a flush always wins.
module pipe_entry_reg #(
  parameter int CTRL_W = 15,
  parameter int DATA_W = 175
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              clr_ctrl_i,
  input  logic              clr_data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= '0;
      data_q <= '0;
    end else begin
      if (clr_ctrl_i)  ctrl_q <= '0;
      else if (load_i) ctrl_q <= ctrl_i;
      if (clr_data_i)  data_q <= '0;
      else if (load_i) data_q <= data_i;
    end
  end

  assign ctrl_o = ctrl_q;
  assign data_o = data_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Reusable pipeline stage register with valid/ready handshake,
// optional 2-entry skid buffer, flush with bubble and drop count.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int CTRL_W         = IDEX_CTRL_W,
  parameter int DATA_W         = IDEX_DATA_W,
  parameter int SKID           = 1,
  parameter int FLUSH_CLR_DATA = 0,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  drop_cnt
);

  stage_state_e      state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic [1:0]        occ_q, occ_d;
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic [CNT_W:0]    drop_sum;
  logic [1:0]        drop_inc;
  logic              in_fire, out_fire;
  logic              m_load, m_from_s, clr_data;
  logic [CTRL_W-1:0] m_ctrl, s_ctrl, m_ctrl_in;
  logic [DATA_W-1:0] m_data, s_data, m_data_in;

  assign out_valid = (state_q != EMPTY);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign clr_data  = flush && (FLUSH_CLR_DATA != 0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      occ_q      <= 2'd0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      occ_q      <= occ_d;
      drop_q     <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (SKID != 0) begin
      unique case (state_q)
        EMPTY: if (in_fire) state_d = ONE;
        ONE: begin
          if (in_fire && !out_ready)
            state_d = FULL;
          else if (out_fire && !in_valid)
            state_d = EMPTY;
        end
        FULL:    if (out_fire) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end else begin
      if (in_fire)       state_d = ONE;
      else if (out_fire) state_d = EMPTY;
    end
    if (flush) state_d = EMPTY;

    in_ready_d = (state_d != FULL);
    occ_d      = occ_of(state_d);

    // Head consumed in the flush cycle is delivered, not dropped.
    drop_inc = occ_q - {1'b0, out_fire};
    drop_sum = {1'b0, drop_q} + (CNT_W+1)'(drop_inc);
    drop_d   = drop_q;
    if (flush)
      drop_d = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
  end

  always_comb begin
    m_from_s  = (state_q == FULL);
    m_load    = !flush && (m_from_s ? out_fire
                : (in_fire && (state_q == EMPTY || out_ready)));
    m_ctrl_in = m_from_s ? s_ctrl : in_ctrl;
    m_data_in = m_from_s ? s_data : in_data;
    out_ctrl  = out_valid ? m_ctrl : '0;
    out_data  = m_data;
    occupancy = occ_q;
  end

  pipe_entry_reg #(
    .CTRL_W(CTRL_W),
    .DATA_W(DATA_W)
  ) u_m (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (m_load),
    .clr_ctrl_i(flush),
    .clr_data_i(clr_data),
    .ctrl_i    (m_ctrl_in),
    .data_i    (m_data_in),
    .ctrl_o    (m_ctrl),
    .data_o    (m_data)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic s_load;
      assign s_load   = !flush && (state_q == ONE)
                        && in_fire && !out_ready;
      assign in_ready = in_ready_q;
      pipe_entry_reg #(
        .CTRL_W(CTRL_W),
        .DATA_W(DATA_W)
      ) u_s (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (s_load),
        .clr_ctrl_i(flush),
        .clr_data_i(clr_data),
        .ctrl_i    (in_ctrl),
        .data_i    (in_data),
        .ctrl_o    (s_ctrl),
        .data_o    (s_data)
      );
    end else begin : g_single
      assign in_ready = !out_valid || out_ready;
      assign s_ctrl   = '0;
      assign s_data   = '0;
    end
  endgenerate

  assign drop_cnt = drop_q;

endmodule
